siggen_sequencer: RTL and testbench

Burst/continuous address sequencer for the dual-port sine ROM in the signal generator. It drives both ROM read addresses from a phase accumulator, with a programmable phase step and a programmable port-2 phase offset. It produces a `data_valid` strobe aligned with the ROM's registered outputs, and runs fixed-length bursts or free-runs until stopped. It sits between the top-level control inputs and the ROM.

---
 rtl/siggen_sequencer_if.sv | 27 ++
 rtl/siggen_sequencer.sv | 98 +++++++++
 tb/tb_siggen_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/siggen_sequencer_if.sv
// Control and ROM-address bundle between the signal-generator control block
// and the sine-ROM address sequencer.
interface siggen_sequencer_if #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned COUNT_WIDTH   = 16
);
  logic                     start;
  logic                     stop;
  logic [ADDRESS_WIDTH-1:0] incr;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic [COUNT_WIDTH-1:0]   length;
  logic [ADDRESS_WIDTH-1:0] addr1;
  logic [ADDRESS_WIDTH-1:0] addr2;
  logic                     data_valid;
  logic                     busy;
  logic                     done;

  modport master (
    output start, stop, incr, offset, length,
    input  addr1, addr2, data_valid, busy, done
  );

  modport slave (
    input  start, stop, incr, offset, length,
    output addr1, addr2, data_valid, busy, done
  );
endinterface

// File: rtl/siggen_sequencer.sv
// Burst/continuous phase-accumulator address sequencer for the dual-port sine ROM.
// Drives both ROM addresses and flags samples in step with the ROM's output register.
module siggen_sequencer #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned COUNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  siggen_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] phase_q, phase_d;
  logic [ADDRESS_WIDTH-1:0] incr_q, incr_d;
  logic [ADDRESS_WIDTH-1:0] offset_q, offset_d;
  logic [ADDRESS_WIDTH-1:0] addr2_q, addr2_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic [COUNT_WIDTH-1:0]   length_q, length_d;
  logic                     valid_q;
  logic                     last_sample;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    incr_d      = incr_q;
    offset_d    = offset_q;
    count_d     = count_q;
    length_d    = length_q;
    last_sample = ((length_q != '0) && (count_q == length_q - COUNT_WIDTH'(1)))
                  || bus.stop;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          incr_d   = bus.incr;
          offset_d = bus.offset;
          length_d = bus.length;
          phase_d  = '0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // The final sample keeps its phase so addr1/addr2 hold it through IDLE.
        if (last_sample) begin
          state_d = DRAIN;
        end else begin
          phase_d = phase_q + incr_q;
          count_d = count_q + COUNT_WIDTH'(1);
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered so port 2 moves on the same edge as the phase register.
    addr2_d = phase_d + offset_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      incr_q   <= '0;
      offset_q <= '0;
      addr2_q  <= '0;
      count_q  <= '0;
      length_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      incr_q   <= incr_d;
      offset_q <= offset_d;
      addr2_q  <= addr2_d;
      count_q  <= count_d;
      length_q <= length_d;
      valid_q  <= (state_q == RUN);
    end
  end

  assign bus.addr1      = phase_q;
  assign bus.addr2      = addr2_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DRAIN);

endmodule

// File: tb/tb_siggen_sequencer.sv
// Randomized self-checking bench for siggen_sequencer against a cycle-indexed
// arithmetic model of bursts (sample k sits at k*incr, delivered one cycle later).
module tb_siggen_sequencer;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  logic [AW-1:0] last_a1 = '0;
  logic [AW-1:0] last_a2 = '0;
  logic [AW-1:0] rom_a1, rom_a2;

  siggen_sequencer_if #(.ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) u_if ();

  siggen_sequencer #(.ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  // ROM address registers: model what the ROM outputs correspond to.
  always @(posedge clk) begin
    rom_a1 <= u_if.addr1;
    rom_a2 <= u_if.addr2;
  end

  task automatic idle_inputs();
    u_if.start  = 1'b0;
    u_if.stop   = 1'b0;
    u_if.incr   = '0;
    u_if.offset = '0;
    u_if.length = '0;
  endtask

  // One complete sequence. Cycle 0 is the start cycle; stop_cycle=0 means no stop.
  task automatic run_burst(input string name, input logic [AW-1:0] inc,
                           input logic [AW-1:0] off, input logic [CW-1:0] len,
                           input int stop_cycle, input bit noise, input bit stop_at_start);
    int n;
    int idx;
    logic [AW-1:0] e_a1, e_a2, e_r1, e_r2;
    logic e_busy, e_done, e_dv;
    if (len != 0 && (stop_cycle == 0 || int'(len) < stop_cycle)) n = int'(len);
    else n = stop_cycle;
    @(negedge clk);
    u_if.start  = 1'b1;
    u_if.stop   = stop_at_start;
    u_if.incr   = inc;
    u_if.offset = off;
    u_if.length = len;
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk);
      idx    = (c <= n) ? c - 1 : n - 1;
      e_a1   = AW'(idx * int'(inc));
      e_a2   = AW'(e_a1 + off);
      e_busy = (c <= n + 1);
      e_done = (c == n + 1);
      e_dv   = (c >= 2) && (c <= n + 1);
      checks++;
      if (u_if.addr1 !== e_a1)
        $display("FAIL %s addr1 cycle %0d: got %0d expected %0d", name, c, u_if.addr1, e_a1);
      else passes++;
      checks++;
      if (u_if.addr2 !== e_a2)
        $display("FAIL %s addr2 cycle %0d: got %0d expected %0d", name, c, u_if.addr2, e_a2);
      else passes++;
      checks++;
      if ({u_if.busy, u_if.done, u_if.data_valid} !== {e_busy, e_done, e_dv})
        $display("FAIL %s busy/done/valid cycle %0d: got %b%b%b expected %b%b%b", name, c,
                 u_if.busy, u_if.done, u_if.data_valid, e_busy, e_done, e_dv);
      else passes++;
      if (e_dv) begin
        e_r1 = AW'((c - 2) * int'(inc));
        e_r2 = AW'(e_r1 + off);
        checks++;
        if ({rom_a1, rom_a2} !== {e_r1, e_r2})
          $display("FAIL %s rom sample cycle %0d: got %0d/%0d expected %0d/%0d", name, c,
                   rom_a1, rom_a2, e_r1, e_r2);
        else passes++;
      end
      u_if.stop  = (c == stop_cycle) && (c <= n + 1);
      u_if.start = noise && (c <= n + 1) ? 1'($urandom % 2) : 1'b0;
      if (noise) begin
        u_if.incr   = AW'($urandom);
        u_if.offset = AW'($urandom);
        u_if.length = CW'($urandom);
      end
    end
    u_if.stop  = 1'b0;
    u_if.start = 1'b0;
    last_a1 = AW'((n - 1) * int'(inc));
    last_a2 = AW'(last_a1 + off);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({u_if.addr1, u_if.addr2, u_if.data_valid, u_if.busy, u_if.done} !== '0)
      $display("FAIL reset outputs: got %0d %0d %b%b%b expected all zero",
               u_if.addr1, u_if.addr2, u_if.data_valid, u_if.busy, u_if.done);
    else passes++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_burst();
    run_burst("basic", 8'd1, 8'd64, 16'd4, 0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    run_burst("wrap", 8'd100, 8'd200, 16'd4, 0, 1'b0, 1'b0);
  endtask

  task automatic test_continuous_stop();
    run_burst("continuous", 8'd3, 8'd17, 16'd0, 10, 1'b0, 1'b0);
    run_burst("early_stop", 8'd9, 8'd250, 16'd8, 3, 1'b0, 1'b0);
  endtask

  task automatic test_single_sample();
    run_burst("single", 8'd5, 8'd33, 16'd1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_controls();
    run_burst("noisy", 8'd7, 8'd128, 16'd6, 0, 1'b1, 1'b0);
    run_burst("start_stop_same", 8'd11, 8'd2, 16'd3, 0, 1'b0, 1'b1);
    u_if.stop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({u_if.busy, u_if.done, u_if.data_valid, u_if.addr1, u_if.addr2} !==
          {3'b000, last_a1, last_a2})
        $display("FAIL stop_idle: got %b%b%b %0d/%0d expected 000 %0d/%0d",
                 u_if.busy, u_if.done, u_if.data_valid, u_if.addr1, u_if.addr2, last_a1, last_a2);
      else passes++;
    end
    u_if.stop = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    u_if.start = 1'b1; u_if.incr = 8'd7; u_if.offset = 8'd9; u_if.length = 16'd20;
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({u_if.addr1, u_if.addr2, u_if.data_valid, u_if.busy, u_if.done} !== '0)
      $display("FAIL reset_mid_run: got %0d %0d %b%b%b expected all zero",
               u_if.addr1, u_if.addr2, u_if.data_valid, u_if.busy, u_if.done);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    run_burst("after_reset", 8'd13, 8'd40, 16'd5, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] exp_a1 [6] = '{8'd0, 8'd3, 8'd3, 8'd3, 8'd0, 8'd3};
    logic          exp_bz [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    @(negedge clk);
    u_if.start = 1'b1; u_if.incr = 8'd3; u_if.offset = 8'd1; u_if.length = 16'd2;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if ({u_if.busy, u_if.addr1} !== {exp_bz[c-1], exp_a1[c-1]})
        $display("FAIL back_to_back cycle %0d: got busy=%b addr1=%0d expected busy=%b addr1=%0d",
                 c, u_if.busy, u_if.addr1, exp_bz[c-1], exp_a1[c-1]);
      else passes++;
    end
    u_if.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (u_if.busy !== 1'b0)
      $display("FAIL back_to_back settle: got busy=%b expected 0", u_if.busy);
    else passes++;
    last_a1 = 8'd3;
    last_a2 = 8'd4;
  endtask

  task automatic test_random();
    logic [CW-1:0] len;
    int sc;
    for (int i = 0; i < 25; i++) begin
      len = CW'($urandom_range(0, 12));
      if (len == 0) sc = $urandom_range(1, 15);
      else sc = ($urandom % 3 == 0) ? $urandom_range(1, int'(len) + 1) : 0;
      run_burst("random", AW'($urandom), AW'($urandom), len, sc,
                1'($urandom % 2), ($urandom % 4) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_wrap();
    test_continuous_stop();
    test_single_sample();
    test_ignored_controls();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
